// File: rtl/level_pkg.sv
// Shared definitions for the level logic: game state encoding, background
// tile codes, and a small popcount helper used for coin bookkeeping.
package level_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } level_state_t;

    typedef enum logic [2:0] {
        BDR = 3'd0,
        SKY = 3'd1,
        BLK = 3'd2,
        GND = 3'd3,
        TKN = 3'd4,
        CK1 = 3'd5,
        CK2 = 3'd6
    } tile_code_t;

    // Number of set bits in a coin vector (coin count never exceeds 16).
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int k = 0; k < 16; k++) begin
            n = n + {4'd0, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/second_ticker.sv
// One-second tick generator: counts vga_clock cycles while enabled and emits a
// single-cycle tick every TICKS_PER_SECOND cycles; clear restarts the count.
module second_ticker #(
    parameter int TICKS_PER_SECOND = 25_000_000
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SECOND - 1);

    logic [CW-1:0] count_reg;

    assign tick = enable && !clear && (count_reg == LAST);

    // Cycle counter wraps on each tick; clear wins over enable.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tick ? '0 : count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/level_coin_tracker.sv
// Level coin tracker: detects Mario touching coins, keeps collected flags and
// the remaining-coin count, queues SKY tile writes for collected coins (lowest
// index first), runs the level timer and the IDLE/PLAY/WIN/LOSE state machine.
// Optional feature macro: LEVEL_LIVES_EN adds NUM_LIVES and a lives output.
module level_coin_tracker
    import level_pkg::*;
#(
    parameter int NUM_COINS        = 4,
    parameter int CHARACTER_WIDTH  = 42,
    parameter int BLOCK_WIDTH      = 40,
    parameter int TIME_LIMIT       = 100,
    parameter int TICKS_PER_SECOND = 25_000_000
`ifdef LEVEL_LIVES_EN
    ,
    parameter int NUM_LIVES        = 3
`endif
) (
    input  logic                               vga_clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic signed [31:0]                 mario_x,
    input  logic signed [31:0]                 mario_y,
    input  logic [NUM_COINS*5-1:0]             coin_col,
    input  logic [NUM_COINS*4-1:0]             coin_row,
    input  logic                               enemy_hit,
    output logic                               tile_wr_valid,
    input  logic                               tile_wr_ready,
    output logic [3:0]                         tile_wr_row,
    output logic [4:0]                         tile_wr_col,
    output logic [NUM_COINS-1:0]               collected,
    output logic [$clog2(NUM_COINS+1)-1:0]     coins_left,
    output logic [7:0]                         seconds_left,
    output logic [1:0]                         state,
    output logic                               win,
    output logic                               lose
`ifdef LEVEL_LIVES_EN
    ,
    output logic [1:0]                         lives
`endif
);

    localparam int CLW = $clog2(NUM_COINS + 1);

    level_state_t         state_reg, state_next;
    logic [NUM_COINS-1:0] collected_reg, pending_reg, wr_sel_reg;
    logic [CLW-1:0]       coins_left_reg, coins_left_next;
    logic [7:0]           seconds_left_reg;
    logic                 wr_valid_reg;
    logic [3:0]           wr_row_reg;
    logic [4:0]           wr_col_reg;

    logic [NUM_COINS-1:0] touch, new_coins, avail, sel_onehot;
    logic                 sel_found, handshake, tick, lose_cond;
    logic [3:0]           sel_row;
    logic [4:0]           sel_col;

    // Per-coin bounding-box overlap test, inclusive edges, signed pixel space.
    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_touch
        logic signed [31:0] tile_x, tile_y;
        assign tile_x = $signed({27'd0, coin_col[5*gi +: 5]}) * BLOCK_WIDTH;
        assign tile_y = $signed({28'd0, coin_row[4*gi +: 4]}) * BLOCK_WIDTH;
        assign touch[gi] = (mario_x <= tile_x + BLOCK_WIDTH - 1) &&
                           (mario_x + CHARACTER_WIDTH - 1 >= tile_x) &&
                           (mario_y <= tile_y + BLOCK_WIDTH - 1) &&
                           (mario_y + CHARACTER_WIDTH - 1 >= tile_y);
    end

    assign new_coins       = (state_reg == PLAY) ? (touch & ~collected_reg) : '0;
    assign coins_left_next = coins_left_reg - CLW'(popcount16(16'(new_coins)));
    assign handshake       = wr_valid_reg && tile_wr_ready;
    // The coin just accepted must not be re-offered on the handshake cycle.
    assign avail           = handshake ? (pending_reg & ~wr_sel_reg) : pending_reg;

    // Pick the lowest-index pending coin for the next tile write.
    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        sel_row    = '0;
        sel_col    = '0;
        for (int k = NUM_COINS - 1; k >= 0; k--) begin
            if (avail[k]) begin
                sel_found     = 1'b1;
                sel_onehot    = '0;
                sel_onehot[k] = 1'b1;
                sel_row       = coin_row[4*k +: 4];
                sel_col       = coin_col[5*k +: 5];
            end
        end
    end

    second_ticker #(
        .TICKS_PER_SECOND(TICKS_PER_SECOND)
    ) u_second_ticker (
        .vga_clock(vga_clock),
        .reset    (reset),
        .enable   (state_reg == PLAY),
        .clear    (start),
        .tick     (tick)
    );

`ifdef LEVEL_LIVES_EN
    localparam int GW = $clog2(TICKS_PER_SECOND + 1);

    logic          hit_d_reg, hit_accept;
    logic [GW-1:0] guard_reg;
    logic [1:0]    lives_reg;

    assign hit_accept = (state_reg == PLAY) && enemy_hit && !hit_d_reg && (guard_reg == '0);
    assign lose_cond  = (hit_accept && lives_reg <= 2'd1) || (seconds_left_reg == 8'd0);
    assign lives      = lives_reg;

    // Lives counter with a one-second hit guard after every accepted hit.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            hit_d_reg <= 1'b0;
            guard_reg <= '0;
            lives_reg <= 2'(NUM_LIVES);
        end else begin
            hit_d_reg <= enemy_hit;
            if (start) begin
                guard_reg <= '0;
                lives_reg <= 2'(NUM_LIVES);
            end else if (hit_accept) begin
                guard_reg <= GW'(TICKS_PER_SECOND);
                lives_reg <= (lives_reg != 2'd0) ? lives_reg - 2'd1 : 2'd0;
            end else if (guard_reg != '0) begin
                guard_reg <= guard_reg - GW'(1);
            end
        end
    end
`else
    assign lose_cond = enemy_hit || (seconds_left_reg == 8'd0);
`endif

    // State register.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_next_apply: state_reg <= state_next;
        end
    end

    // Next-state logic; the win test uses the post-collection count so a final
    // coin beats a simultaneous losing event.
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = PLAY;
        end else begin
            case (state_reg)
                PLAY: begin
                    if (coins_left_next == '0) begin
                        state_next = WIN;
                    end else if (lose_cond) begin
                        state_next = LOSE;
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // Coin bookkeeping, timer and tile-write presentation.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            collected_reg    <= '0;
            pending_reg      <= '0;
            wr_sel_reg       <= '0;
            coins_left_reg   <= CLW'(NUM_COINS);
            seconds_left_reg <= 8'(TIME_LIMIT);
            wr_valid_reg     <= 1'b0;
            wr_row_reg       <= '0;
            wr_col_reg       <= '0;
        end else if (start) begin
            collected_reg    <= '0;
            pending_reg      <= '0;
            wr_sel_reg       <= '0;
            coins_left_reg   <= CLW'(NUM_COINS);
            seconds_left_reg <= 8'(TIME_LIMIT);
            wr_valid_reg     <= 1'b0;
        end else begin
            collected_reg  <= collected_reg | new_coins;
            pending_reg    <= (pending_reg | new_coins) & ~(handshake ? wr_sel_reg : '0);
            coins_left_reg <= coins_left_next;
            if (state_reg == PLAY && tick && seconds_left_reg != 8'd0) begin
                seconds_left_reg <= seconds_left_reg - 8'd1;
            end
            // Only load a new write when the channel is idle or just accepted.
            if (!wr_valid_reg || handshake) begin
                wr_valid_reg <= sel_found;
                wr_sel_reg   <= sel_onehot;
                if (sel_found) begin
                    wr_row_reg <= sel_row;
                    wr_col_reg <= sel_col;
                end
            end
        end
    end

    assign tile_wr_valid = wr_valid_reg;
    assign tile_wr_row   = wr_row_reg;
    assign tile_wr_col   = wr_col_reg;
    assign collected     = collected_reg;
    assign coins_left    = coins_left_reg;
    assign seconds_left  = seconds_left_reg;
    assign state         = state_reg;
    assign win           = (state_reg == WIN);
    assign lose          = (state_reg == LOSE);

endmodule

// File: tb/tb_level_coin_tracker.sv
// Scoreboard bench for level_coin_tracker: stimulus pushes expected status
// snapshots and expected tile writes into queues; a negedge monitor pops and
// compares them, and checks tile-write stability while ready is low.
module tb_level_coin_tracker;

    localparam int NC  = 4;
    localparam int TPS = 10;
    localparam int TL  = 3;

    logic               vga_clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic signed [31:0] mario_x, mario_y;
    logic [NC*5-1:0]    coin_col;
    logic [NC*4-1:0]    coin_row;
    logic               enemy_hit = 1'b0;
    logic               tile_wr_valid;
    logic               tile_wr_ready = 1'b1;
    logic [3:0]         tile_wr_row;
    logic [4:0]         tile_wr_col;
    logic [NC-1:0]      collected;
    logic [2:0]         coins_left;
    logic [7:0]         seconds_left;
    logic [1:0]         state;
    logic               win, lose;
`ifdef LEVEL_LIVES_EN
    logic [1:0]         lives;
`endif

    level_coin_tracker #(
        .NUM_COINS       (NC),
        .CHARACTER_WIDTH (42),
        .BLOCK_WIDTH     (40),
        .TIME_LIMIT      (TL),
        .TICKS_PER_SECOND(TPS)
    ) dut (
        .vga_clock    (vga_clock),
        .reset        (reset),
        .start        (start),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .coin_col     (coin_col),
        .coin_row     (coin_row),
        .enemy_hit    (enemy_hit),
        .tile_wr_valid(tile_wr_valid),
        .tile_wr_ready(tile_wr_ready),
        .tile_wr_row  (tile_wr_row),
        .tile_wr_col  (tile_wr_col),
        .collected    (collected),
        .coins_left   (coins_left),
        .seconds_left (seconds_left),
        .state        (state),
        .win          (win),
        .lose         (lose)
`ifdef LEVEL_LIVES_EN
        ,
        .lives        (lives)
`endif
    );

    always #5 vga_clock = ~vga_clock;

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } stat_t;

    typedef struct {
        int row;
        int col;
    } wr_t;

    stat_t stat_q[$];
    wr_t   wr_q[$];
    int    checks = 0;
    int    passes = 0;

    localparam int K_STATE = 0, K_COLL = 1, K_LEFT = 2, K_SECS = 3,
                   K_WIN = 4, K_LOSE = 5, K_VALID = 6, K_LIVES = 7;

    function automatic int actual(input int kind);
        case (kind)
            K_STATE: return int'(state);
            K_COLL:  return int'(collected);
            K_LEFT:  return int'(coins_left);
            K_SECS:  return int'(seconds_left);
            K_WIN:   return int'(win);
            K_LOSE:  return int'(lose);
            K_VALID: return int'(tile_wr_valid);
`ifdef LEVEL_LIVES_EN
            K_LIVES: return int'(lives);
`endif
            default: return -1;
        endcase
    endfunction

    task automatic expect_st(input string name, input int kind, input int exp);
        stat_t s;
        s.name = name;
        s.kind = kind;
        s.exp  = exp;
        stat_q.push_back(s);
    endtask

    task automatic expect_wr(input int row, input int col);
        wr_t w;
        w.row = row;
        w.col = col;
        wr_q.push_back(w);
    endtask

    // Monitor: compare queued status snapshots and every accepted tile write.
    stat_t      mon_s;
    wr_t        mon_w;
    int         mon_act;
    logic       prev_hold = 1'b0;
    logic [3:0] prev_row = '0;
    logic [4:0] prev_col = '0;

    always @(negedge vga_clock) begin
        while (stat_q.size() > 0) begin
            mon_s   = stat_q.pop_front();
            mon_act = actual(mon_s.kind);
            checks++;
            if (mon_act == mon_s.exp) passes++;
            else $display("FAIL %s: got %0d, expected %0d", mon_s.name, mon_act, mon_s.exp);
        end
        if (prev_hold) begin
            checks++;
            if (tile_wr_valid && tile_wr_row == prev_row && tile_wr_col == prev_col) passes++;
            else $display("FAIL tile_hold: got valid=%0d row=%0d col=%0d, expected valid=1 row=%0d col=%0d",
                          tile_wr_valid, tile_wr_row, tile_wr_col, prev_row, prev_col);
        end
        if (tile_wr_valid && tile_wr_ready) begin
            checks++;
            if (wr_q.size() == 0) begin
                $display("FAIL tile_write: got unexpected row=%0d col=%0d, expected no write",
                         tile_wr_row, tile_wr_col);
            end else begin
                mon_w = wr_q.pop_front();
                if (int'(tile_wr_row) == mon_w.row && int'(tile_wr_col) == mon_w.col) begin
                    passes++;
                    $display("tile write row=%0d col=%0d", tile_wr_row, tile_wr_col);
                end else begin
                    $display("FAIL tile_write: got row=%0d col=%0d, expected row=%0d col=%0d",
                             tile_wr_row, tile_wr_col, mon_w.row, mon_w.col);
                end
            end
        end
        prev_hold = tile_wr_valid && !tile_wr_ready;
        prev_row  = tile_wr_row;
        prev_col  = tile_wr_col;
    end

    task automatic step(input int n);
        repeat (n) @(posedge vga_clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic set_coin(input int i, input int col, input int row);
        coin_col[5*i +: 5] = 5'(col);
        coin_row[4*i +: 4] = 4'(row);
    endtask

    task automatic park();
        mario_x = -200;
        mario_y = -200;
    endtask

    initial begin
        park();
        coin_col = '1;
        coin_row = '1;

        // Reset values
        step(1);
        expect_st("rst_state", K_STATE, 0);
        expect_st("rst_collected", K_COLL, 0);
        expect_st("rst_coins_left", K_LEFT, 4);
        expect_st("rst_seconds", K_SECS, TL);
        expect_st("rst_valid", K_VALID, 0);
        expect_st("rst_win", K_WIN, 0);
        expect_st("rst_lose", K_LOSE, 0);
`ifdef LEVEL_LIVES_EN
        expect_st("rst_lives", K_LIVES, 3);
`endif
        step(1);
        reset = 1'b1;
        step(2);
        expect_st("idle_hold", K_STATE, 0);

        // Timeout: seconds expire 30 cycles after start, LOSE one cycle later
        step(1);
        pulse_start();
        expect_st("t1_state_play", K_STATE, 1);
        expect_st("t1_seconds_init", K_SECS, TL);
        step(10);
        expect_st("t1_seconds_after_1s", K_SECS, 2);
        step(20);
        expect_st("t1_seconds_zero", K_SECS, 0);
        expect_st("t1_still_play", K_STATE, 1);
        step(1);
        expect_st("t1_state_lose", K_STATE, 3);
        expect_st("t1_lose_flag", K_LOSE, 1);
        step(3);
        expect_st("t1_seconds_frozen", K_SECS, 0);
        expect_st("t1_lose_held", K_STATE, 3);

        // Single coin, write held while ready is low
        tile_wr_ready = 1'b0;
        set_coin(0, 6, 6);
        step(1);
        pulse_start();
        expect_st("t2_collected_clear", K_COLL, 0);
        mario_x = 240;
        mario_y = 240;
        step(1);
        expect_st("t2_collected", K_COLL, 1);
        expect_st("t2_coins_left", K_LEFT, 3);
        expect_wr(6, 6);
        park();
        step(1);
        expect_st("t2_valid_up", K_VALID, 1);
        step(5);
        expect_st("t2_valid_held", K_VALID, 1);
        tile_wr_ready = 1'b1;
        step(1);
        expect_st("t2_valid_cleared", K_VALID, 0);
        expect_st("t2_collected_kept", K_COLL, 1);

        // Inclusive-edge boundaries around coin 0 at tile (6,6)
        pulse_start();
        mario_x = 198;
        mario_y = 240;
        step(1);
        expect_st("edge_left_miss", K_COLL, 0);
        mario_x = 280;
        step(1);
        expect_st("edge_right_miss", K_COLL, 0);
        mario_x = 279;
        mario_y = 279;
        step(1);
        expect_st("edge_corner_hit", K_COLL, 1);
        expect_wr(6, 6);
        park();
        step(3);
        expect_st("edge_valid_drained", K_VALID, 0);

        // Two coins in one cycle, writes in index order
        set_coin(0, 2, 3);
        set_coin(1, 3, 3);
        pulse_start();
        expect_st("t3_coins_left_init", K_LEFT, 4);
        mario_x = 100;
        mario_y = 120;
        step(1);
        expect_st("t3_collected_pair", K_COLL, 3);
        expect_st("t3_coins_left", K_LEFT, 2);
        expect_wr(3, 2);
        expect_wr(3, 3);
        park();
        step(5);
        expect_st("t3_valid_drained", K_VALID, 0);
        expect_st("t3_state_play", K_STATE, 1);

        // Restart mid-PLAY with two coins collected
        set_coin(2, 2, 4);
        set_coin(3, 3, 4);
        pulse_start();
        expect_st("t4_collected", K_COLL, 0);
        expect_st("t4_coins_left", K_LEFT, 4);
        expect_st("t4_seconds", K_SECS, TL);
        expect_st("t4_state", K_STATE, 1);

        // Final coins together with an enemy hit: WIN wins, writes still drain
        mario_x = 60;
        mario_y = 120;
        step(1);
        expect_st("t5_collected_02", K_COLL, 5);
        expect_st("t5_coins_left", K_LEFT, 2);
        expect_wr(3, 2);
        mario_x = 120;
        enemy_hit = 1'b1;
        step(1);
        expect_st("t5_state_win", K_STATE, 2);
        expect_st("t5_win_flag", K_WIN, 1);
        expect_st("t5_lose_flag", K_LOSE, 0);
        expect_st("t5_collected_all", K_COLL, 15);
        expect_st("t5_coins_left_zero", K_LEFT, 0);
        expect_wr(3, 3);
        expect_wr(4, 2);
        expect_wr(4, 3);
        enemy_hit = 1'b0;
        park();
        step(5);
        expect_st("t5_valid_drained", K_VALID, 0);
        expect_st("t5_win_held", K_STATE, 2);

`ifdef LEVEL_LIVES_EN
        // Lives: hits spaced beyond one second decrement, a quick repeat does not
        pulse_start();
        expect_st("lv_lives_init", K_LIVES, 3);
        enemy_hit = 1'b1;
        step(1);
        expect_st("lv_first_hit", K_LIVES, 2);
        expect_st("lv_still_play", K_STATE, 1);
        enemy_hit = 1'b0;
        step(1);
        enemy_hit = 1'b1;
        step(1);
        expect_st("lv_guarded_hit", K_LIVES, 2);
        enemy_hit = 1'b0;
        step(10);
        enemy_hit = 1'b1;
        step(1);
        expect_st("lv_second_hit", K_LIVES, 1);
        expect_st("lv_play_after_2", K_STATE, 1);
        enemy_hit = 1'b0;
        step(10);
        enemy_hit = 1'b1;
        step(1);
        expect_st("lv_third_hit", K_LIVES, 0);
        expect_st("lv_state_lose", K_STATE, 3);
        enemy_hit = 1'b0;
`else
        // Any enemy hit in PLAY loses immediately
        pulse_start();
        enemy_hit = 1'b1;
        step(1);
        expect_st("t6_state_lose", K_STATE, 3);
        expect_st("t6_lose_flag", K_LOSE, 1);
        expect_st("t6_win_flag", K_WIN, 0);
        enemy_hit = 1'b0;
`endif

        step(3);
        checks++;
        if (wr_q.size() == 0) passes++;
        else $display("FAIL tile_queue_empty: got %0d outstanding writes, expected 0", wr_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
